ysyx_22040365_ifu: RTL and testbench

//  Instruction fetch unit. Drives instruction words into ysyx_22040365_top's decode path.
//  - Holds the PC and issues word reads to instruction memory over a valid/ready request channel.
//  - Accepts read data on a response channel.
//  - Presents {inst, inst_pc} to decode on a valid/ready channel.
//  - Accepts a redirect (jump/branch target) from ex at any time.

---
 rtl/ysyx_22040365_ifu_pkg.sv | 22 ++
 rtl/ysyx_22040365_ifu_if.sv | 29 ++
 rtl/ysyx_22040365_ifu_pc_reg.sv | 35 +++
 rtl/ysyx_22040365_ifu.sv | 86 ++++++++
 tb/tb_ysyx_22040365_ifu.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/ysyx_22040365_ifu_pkg.sv
// Shared widths, reset vector and FSM encoding for the instruction fetch unit.
package ysyx_22040365_ifu_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC   = 64'h0000_0000_8000_0000;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~64'h3;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_t;

  // Sequential fetch address; wraps modulo 2^XLEN with no fault.
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/ysyx_22040365_ifu_if.sv
// Redirect, instruction-memory and decode channels of the fetch unit.
interface ysyx_22040365_ifu_if;
  import ysyx_22040365_ifu_pkg::*;

  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [XLEN-1:0]   inst_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
           imem_resp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
           imem_resp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
  );

endinterface

// File: rtl/ysyx_22040365_ifu_pc_reg.sv
// Program counter: reset load, redirect (word aligned) over sequential +4.
module ysyx_22040365_pc_reg
  import ysyx_22040365_ifu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            redir_i,
  input  logic [XLEN-1:0] redir_pc_i,
  input  logic            inc_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redir_i) begin
      pc_d = redir_pc_i & ALIGN_MASK;
    end else if (inc_i) begin
      pc_d = next_seq_pc(pc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_22040365_ifu.sv
// Instruction fetch unit: one outstanding imem read, buffered output to decode.
module ysyx_22040365_ifu
  import ysyx_22040365_ifu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  ysyx_22040365_ifu_if.master bus
);

  ifu_state_t        state_q, state_d;
  logic              drop_q, drop_d;
  logic [INST_W-1:0] inst_q;
  logic [XLEN-1:0]   inst_pc_q;
  logic [XLEN-1:0]   pc;
  logic              capture;
  logic              pc_inc;

  ysyx_22040365_pc_reg u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .redir_i   (bus.redirect_valid),
    .redir_pc_i(bus.redirect_pc),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    capture = 1'b0;
    pc_inc  = 1'b0;
    unique case (state_q)
      IFU_IDLE: state_d = IFU_REQ;
      IFU_REQ: begin
        if (bus.imem_req_ready) begin
          state_d = IFU_WAIT;
          // A redirect coinciding with acceptance makes that beat stale.
          drop_d  = bus.redirect_valid;
        end
      end
      IFU_WAIT: begin
        if (bus.imem_resp_valid) begin
          drop_d = 1'b0;
          if (drop_q || bus.redirect_valid) begin
            state_d = IFU_REQ;
          end else begin
            state_d = IFU_HOLD;
            capture = 1'b1;
            pc_inc  = 1'b1;
          end
        end else if (bus.redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      IFU_HOLD: begin
        if (bus.redirect_valid || bus.inst_ready) begin
          state_d = IFU_REQ;
        end
      end
      default: state_d = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IFU_IDLE;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      if (capture) begin
        inst_q    <= bus.imem_resp_data;
        inst_pc_q <= pc;
      end
    end
  end

  assign bus.imem_req_valid = (state_q == IFU_REQ);
  assign bus.imem_req_addr  = pc;
  assign bus.inst_valid     = (state_q == IFU_HOLD);
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
// Directed bench for the fetch unit; inputs change and outputs are sampled on negedge.
module tb_ysyx_22040365_ifu;
  import ysyx_22040365_ifu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ysyx_22040365_ifu_if bus ();

  ysyx_22040365_ifu dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // From REQ: accept the request, answer one cycle later, end in HOLD.
  task automatic fetch(input logic [31:0] data);
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = data;
    tick();
    bus.imem_resp_valid = 1'b0;
    $display("fetch: inst=%h inst_pc=%h valid=%b", bus.inst, bus.inst_pc, bus.inst_valid);
  endtask

  initial begin
    rst                 = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.inst_ready      = 1'b0;
    tick();
    tick();
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_inst", 64'(bus.inst), 64'd0);
    chk("rst_inst_pc", bus.inst_pc, 64'd0);
    chk("rst_pc", bus.imem_req_addr, 64'h8000_0000);
    rst = 1'b0;
    tick();
    $display("step1: first request");
    chk("s1_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("s1_req_addr", bus.imem_req_addr, 64'h8000_0000);
    bus.imem_req_ready = 1'b1;
    tick();
    chk("s1_wait_no_req", 64'(bus.imem_req_valid), 64'd0);
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'h0000_0513;
    tick();
    bus.imem_resp_valid = 1'b0;
    chk("s1_inst_valid", 64'(bus.inst_valid), 64'd1);
    chk("s1_inst", 64'(bus.inst), 64'h0000_0513);
    chk("s1_inst_pc", bus.inst_pc, 64'h8000_0000);

    $display("step2: decode stall");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s2_hold_valid", 64'(bus.inst_valid), 64'd1);
      chk("s2_hold_inst", 64'(bus.inst), 64'h0000_0513);
      chk("s2_hold_pc", bus.inst_pc, 64'h8000_0000);
      chk("s2_no_req", 64'(bus.imem_req_valid), 64'd0);
    end
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("s1_next_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("s1_next_req_addr", bus.imem_req_addr, 64'h8000_0004);
    chk("s1_inst_consumed", 64'(bus.inst_valid), 64'd0);

    $display("step3: redirect in WAIT");
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_1000;
    tick();
    bus.redirect_valid = 1'b0;
    chk("s3_wait_no_req", 64'(bus.imem_req_valid), 64'd0);
    tick();
    chk("s3_still_wait", 64'(bus.imem_req_valid), 64'd0);
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    bus.imem_resp_valid = 1'b0;
    chk("s3_dropped", 64'(bus.inst_valid), 64'd0);
    chk("s3_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("s3_req_addr", bus.imem_req_addr, 64'h8000_1000);
    tick();
    chk("s3_no_late_inst", 64'(bus.inst_valid), 64'd0);
    chk("s3_inst_kept", 64'(bus.inst), 64'h0000_0513);

    $display("step4: redirect in HOLD");
    fetch(32'h0010_0093);
    chk("s4_inst_valid", 64'(bus.inst_valid), 64'd1);
    chk("s4_inst_pc", bus.inst_pc, 64'h8000_1000);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0202;
    bus.inst_ready     = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
    chk("s4_inst_dropped", 64'(bus.inst_valid), 64'd0);
    chk("s4_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("s4_req_addr", bus.imem_req_addr, 64'h8000_0200);

    $display("step5: pc wrap");
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus.redirect_valid = 1'b0;
    chk("s5_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("s5_req_addr", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch(32'h0000_0013);
    chk("s5_inst", 64'(bus.inst), 64'h0000_0013);
    chk("s5_inst_pc", bus.inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("s5_wrap_addr", bus.imem_req_addr, 64'd0);

    $display("step6: reset during WAIT");
    bus.imem_req_ready = 1'b1;
    tick();
    bus.imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("s6_rst_inst_pc", bus.inst_pc, 64'd0);
    chk("s6_rst_inst", 64'(bus.inst), 64'd0);
    rst = 1'b0;
    bus.imem_resp_valid = 1'b1;
    bus.imem_resp_data  = 32'hBAD0_BAD0;
    tick();
    bus.imem_resp_valid = 1'b0;
    chk("s6_late_ignored", 64'(bus.inst_valid), 64'd0);
    chk("s6_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("s6_req_addr", bus.imem_req_addr, 64'h8000_0000);
    chk("s6_inst_clear", 64'(bus.inst), 64'd0);
    fetch(32'h0000_0ABC);
    chk("s6_refetch_inst", 64'(bus.inst), 64'h0000_0ABC);
    chk("s6_refetch_pc", bus.inst_pc, 64'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
